// File: rtl/cache_arbiter.sv
// Two-client line arbiter: the I-cache and D-cache share one physical memory port.
// Ties alternate fairly, each transfer ends in a one-cycle DONE gap, and tied IDLE cycles are counted.
//   state   | meaning
//   IDLE    | sample requests, grant one, latch address/op/data
//   SERVE_I | I-cache line read on pmem, wait for pmem_resp
//   SERVE_D | D-cache line read or writeback on pmem, wait for pmem_resp
//   DONE    | one quiet cycle so requesters can drop their request
module cache_arbiter #(
    parameter logic [15:0] CONFLICT_SAT = 16'hFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  conflict_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_last_d;
    logic           r_write;
    logic [31:0]    r_addr;
    logic [255:0]   r_wdata;
    logic [255:0]   r_i_line;
    logic [255:0]   r_d_line;
    logic [15:0]    r_conflicts;

    logic           w_i_req;
    logic           w_d_req;
    logic           w_conflict;
    logic           w_grant_i;
    logic           w_grant_d;
    logic           w_serving;

    assign w_i_req    = i_read;
    assign w_d_req    = d_read | d_write;
    assign w_conflict = (r_state == IDLE) && w_i_req && w_d_req;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // On a tie the grant goes to whoever was not served last.
                if (w_i_req && w_d_req) begin
                    w_grant_i = r_last_d;
                    w_grant_d = ~r_last_d;
                end else begin
                    w_grant_i = w_i_req;
                    w_grant_d = w_d_req;
                end
                if (w_grant_i) begin
                    w_state_nxt = SERVE_I;
                end else if (w_grant_d) begin
                    w_state_nxt = SERVE_D;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    w_state_nxt = DONE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 256'd0;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= i_address & LINE_MASK;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
            r_write  <= d_write;
            r_addr   <= d_address & LINE_MASK;
            if (d_write) begin
                r_wdata <= d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_line <= 256'd0;
            r_d_line <= 256'd0;
        end else if (pmem_resp) begin
            if (r_state == SERVE_I) begin
                r_i_line <= pmem_rdata;
            end
            if (r_state == SERVE_D) begin
                r_d_line <= pmem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflicts <= 16'd0;
        end else if (w_conflict && (r_conflicts != CONFLICT_SAT)) begin
            r_conflicts <= r_conflicts + 16'd1;
        end
    end

    assign w_serving = (r_state == SERVE_I) || (r_state == SERVE_D);

    assign pmem_read      = w_serving & ~r_write;
    assign pmem_write     = w_serving & r_write;
    assign pmem_address   = r_addr;
    assign pmem_wdata     = r_wdata;
    assign i_resp         = (r_state == SERVE_I) & pmem_resp;
    assign d_resp         = (r_state == SERVE_D) & pmem_resp;
    assign i_rdata        = i_resp ? pmem_rdata : r_i_line;
    assign d_rdata        = d_resp ? pmem_rdata : r_d_line;
    assign conflict_count = r_conflicts;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomised and directed bench for cache_arbiter against a transaction-level reference model.
module tb_cache_arbiter;

    localparam logic [15:0] SAT = 16'd20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [15:0]  conflict_count;

    cache_arbiter #(.CONFLICT_SAT(SAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: who currently owns the memory port (0 none, 1 I, 2 D),
    // whether the post-transfer gap is pending, and the latched transfer.
    int           m_owner;
    bit           m_gap;
    bit           m_last_was_d;
    bit           m_write;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic [255:0] m_i_line;
    logic [255:0] m_d_line;
    int           m_conf;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_gap = 0; m_last_was_d = 0; m_write = 0;
        m_addr = '0; m_wdata = '0; m_i_line = '0; m_d_line = '0; m_conf = 0;
    endtask

    task automatic check_outputs();
        logic e_ir, e_dr;
        e_ir = (m_owner == 1) && pmem_resp;
        e_dr = (m_owner == 2) && pmem_resp;
        chk("pmem_read", pmem_read, (m_owner != 0) && !m_write);
        chk("pmem_write", pmem_write, (m_owner != 0) && m_write);
        chk("strobe_excl", pmem_read & pmem_write, 0);
        chk("pmem_address", pmem_address, m_addr);
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("i_resp", i_resp, e_ir);
        chk("d_resp", d_resp, e_dr);
        chk("i_rdata", i_rdata, e_ir ? pmem_rdata : m_i_line);
        chk("d_rdata", d_rdata, e_dr ? pmem_rdata : m_d_line);
        chk("conflict_count", conflict_count, m_conf[15:0]);
    endtask

    task automatic model_edge();
        bit wi, wd;
        int who;
        if (m_owner != 0) begin
            if (pmem_resp) begin
                if (m_owner == 1) m_i_line = pmem_rdata;
                else m_d_line = pmem_rdata;
                m_owner = 0;
                m_gap = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            wi = i_read;
            wd = d_read | d_write;
            who = 0;
            if (wi && wd) begin
                if (m_conf < int'(SAT)) m_conf++;
                who = m_last_was_d ? 1 : 2;
            end else if (wi) who = 1;
            else if (wd) who = 2;
            if (who == 1) begin
                m_addr = {i_address[31:5], 5'b0};
                m_write = 0;
                m_last_was_d = 0;
                m_owner = 1;
            end else if (who == 2) begin
                m_addr = {d_address[31:5], 5'b0};
                m_write = d_write;
                if (d_write) m_wdata = d_wdata;
                m_last_was_d = 1;
                m_owner = 2;
            end
        end
    endtask

    // Inputs must be set before calling; returns 1 time unit after the clock edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int order[$];
    logic [255:0] line_a;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_conflicts", conflict_count, 0);
        rst_n = 1'b1;

        // I-cache read alone
        i_read = 1; i_address = 32'h0000_1234;
        step();
        i_read = 0;
        chk("ird_addr", pmem_address, 32'h0000_1220);
        chk("ird_read", pmem_read, 1);
        step(); step();
        line_a = rnd256();
        pmem_rdata = line_a; pmem_resp = 1;
        #1;
        chk("ird_resp", i_resp, 1);
        chk("ird_data", i_rdata, line_a);
        chk("ird_dresp", d_resp, 0);
        step();
        pmem_resp = 0; pmem_rdata = rnd256();
        #1;
        chk("ird_done_resp", i_resp, 0);
        chk("ird_done_strobe", pmem_read, 0);
        chk("ird_hold", i_rdata, line_a);
        step();

        // D-cache writeback
        d_write = 1; d_address = 32'h8000_0040; d_wdata = {32{8'hA5}};
        step();
        d_write = 0;
        chk("dwr_write", pmem_write, 1);
        chk("dwr_read", pmem_read, 0);
        chk("dwr_addr", pmem_address, 32'h8000_0040);
        chk("dwr_data", pmem_wdata, {32{8'hA5}});
        step();
        pmem_resp = 1;
        #1;
        chk("dwr_resp", d_resp, 1);
        step();
        pmem_resp = 0;
        step();

        // Alternation under continuous conflict
        do_reset();
        i_read = 1; d_read = 1; pmem_resp = 1;
        i_address = 32'h0000_2000; d_address = 32'h0000_3000;
        order.delete();
        for (int n = 0; n < 12; n++) begin
            step();
            if (d_resp) order.push_back(2);
            if (i_resp) order.push_back(1);
        end
        chk("alt_len", order.size(), 4);
        if (order.size() == 4) begin
            chk("alt_0", order[0], 2);
            chk("alt_1", order[1], 1);
            chk("alt_2", order[2], 2);
            chk("alt_3", order[3], 1);
        end
        chk("alt_conflicts", conflict_count, 4);
        i_read = 0; d_read = 0; pmem_resp = 0;
        step();

        // Reset in the middle of a D writeback
        d_write = 1; d_address = 32'h0000_4440;
        step();
        step();
        pmem_resp = 1;
        rst_n = 1'b0;
        #1;
        chk("mrst_write", pmem_write, 0);
        chk("mrst_dresp", d_resp, 0);
        chk("mrst_iresp", i_resp, 0);
        model_reset();
        d_write = 0; pmem_resp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_conflicts", conflict_count, 0);
        step();
        chk("mrst_idle", pmem_read | pmem_write, 0);

        // Address changes after grant are ignored
        i_read = 1; i_address = 32'hDEAD_BEEF;
        step();
        i_address = 32'h1111_1111;
        step();
        chk("hold_addr", pmem_address, 32'hDEAD_BEE0);
        step();
        chk("hold_addr2", pmem_address, 32'hDEAD_BEE0);
        i_read = 0; pmem_resp = 1;
        step();
        pmem_resp = 0;
        step();

        // Counter saturation
        do_reset();
        i_read = 1; d_write = 1; pmem_resp = 1;
        for (int n = 0; n < 3 * (int'(SAT) + 5); n++) step();
        chk("sat_count", conflict_count, SAT);
        i_read = 0; d_write = 0; pmem_resp = 0;
        step();

        // Random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            i_read = ($urandom_range(0, 1) == 1);
            d_read = ($urandom_range(0, 2) == 0);
            d_write = ($urandom_range(0, 2) == 0);
            i_address = $urandom;
            d_address = $urandom;
            d_wdata = rnd256();
            pmem_rdata = rnd256();
            pmem_resp = ($urandom_range(0, 4) < 2);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have these ports, with the clock and reset listed first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_read  in  1  I-cache line read request.
- i_address  in  32  I-cache line address.
- i_rdata  out  256  line returned to the I-cache.
- i_resp  out  1  I-cache request complete.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_address  in  32  D-cache line address.
- d_wdata  in  256  D-cache writeback line.
- d_rdata  out  256  line returned to the D-cache.
- d_resp  out  1  D-cache request complete.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  32  physical memory line address.
- pmem_wdata  out  256  physical memory write data.
- pmem_rdata  in  256  physical memory read data.
- pmem_resp  in  1  physical memory transfer complete.
- conflict_count  out  16  number of cycles in IDLE where both caches were requesting.

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, SERVE_I, SERVE_D and DONE.
REQ-003 In IDLE with only an I-request pending (i_read=1), the next state SHALL be SERVE_I.
REQ-004 In IDLE with only a D-request pending (d_read|d_write=1), the next state SHALL be SERVE_D.
REQ-005 In IDLE with both requests pending, the grant SHALL go to the requester not served by the most recent grant; the last_grant register SHALL reset to I, so D wins the first conflict.
REQ-006 On the granting edge, the selected address SHALL be latched with bits [4:0] forced to 0, the operation (read/write) SHALL be latched, and d_wdata SHALL be latched for writes.
REQ-007 In SERVE_I and SERVE_D, pmem_read or pmem_write SHALL be driven from the latched operation, and pmem_address/pmem_wdata SHALL be driven from the latched registers; these outputs SHALL hold stable until pmem_resp.
REQ-008 If d_read and d_write are both 1 at grant, the request SHALL be treated as a write.
REQ-009 In SERVE_x, while pmem_resp=1, x_resp SHALL be 1 and x_rdata SHALL equal pmem_rdata combinationally, and the next state SHALL be DONE; otherwise the FSM SHALL remain in SERVE_x.
REQ-010 Outside SERVE_x with pmem_resp=1, i_resp and d_resp SHALL be 0; i_rdata/d_rdata SHALL hold their last-registered line (0 after reset).
REQ-011 DONE SHALL last exactly one cycle, with no pmem strobes and no resp, then return to IDLE; this lets requesters deassert before re-arbitration.
REQ-012 A request that remains asserted in IDLE after DONE SHALL be treated as a new request.
REQ-013 pmem_read and pmem_write SHALL never both be 1.
REQ-014 Minimum latency from request to resp SHALL be 2 cycles (grant edge, then SERVE cycle with pmem_resp=1); throughput SHALL be at most one transfer per 3 cycles.
REQ-015 conflict_count SHALL increment by 1 for each IDLE cycle with both requests pending, and SHALL saturate at 16'hFFFF.
REQ-016 Requests SHALL be sampled only in IDLE; changes on i_*/d_* inputs during SERVE/DONE SHALL have no effect.
REQ-017 A pmem_resp arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-018 When rst_n=0, the block SHALL immediately (asynchronously) set the FSM to IDLE, last_grant=I, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0 and conflict_count=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no resp issued.
REQ-020 After rst_n rises, the first grant decision SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-021 I read alone: i_read=1, i_address=32'h0000_1234, pmem_resp=1 after 3 cycles -> pmem_address=32'h0000_1220, pmem_read=1, one-cycle i_resp with i_rdata=pmem_rdata, d_resp=0.
REQ-022 D writeback: d_write=1, d_address=32'h8000_0040, d_wdata=256'hA5...A5 -> pmem_write=1 with the same address and data, one-cycle d_resp, pmem_read=0 throughout.
REQ-023 Conflict alternation: both caches request continuously for 4 transfers -> grant order D, I, D, I and conflict_count=4.
REQ-024 Mid-transfer reset: rst_n=0 during SERVE_D before pmem_resp -> pmem_write=0 and all resp=0 in the same cycle; after release the FSM is in IDLE and conflict_count=0.
REQ-025 Input change during service: change i_address after grant -> pmem_address remains the latched value until resp.
REQ-026 Saturation: force 65540 conflict cycles -> conflict_count=16'hFFFF.
